// File: rtl/router_pkg.sv
// Shared definitions for the router packet FIFO: header field positions and helpers.
package router_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_LSB   = 0;
  localparam int unsigned ADDR_MSB   = 1;
  localparam int unsigned LEN_LSB    = 2;

  // Payload length carried in a header byte (caller truncates to its LEN width).
  function automatic logic [31:0] hdr_len(input logic [31:0] data);
    return data >> LEN_LSB;
  endfunction

endpackage

// File: rtl/router_pkt_tracker.sv
// Packet boundary tracker: loads LEN+1 on a header, counts down per byte,
// and flags the byte that closes the packet.
module router_pkt_tracker #(
  parameter int unsigned LEN_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             dec_i,
  output logic [LEN_W:0]   rem_o,
  output logic             done_c_o
);

  localparam int unsigned REM_W = LEN_W + 1;

  logic [REM_W-1:0] rem_q;
  logic [REM_W-1:0] rem_d;
  logic             done_c;

  // Next remaining-byte count; done fires on the 1->0 step.
  always_comb begin
    rem_d  = rem_q;
    done_c = 1'b0;
    if (load_i) begin
      rem_d = REM_W'(len_i) + REM_W'(1);
    end else if (dec_i && (rem_q != '0)) begin
      rem_d  = rem_q - REM_W'(1);
      done_c = (rem_q == REM_W'(1));
    end
  end

  // Remaining-byte register.
  always_ff @(posedge clk_i) begin
    if (rst_i) rem_q <= '0;
    else       rem_q <= rem_d;
  end

  assign rem_o    = rem_q;
  assign done_c_o = done_c;

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO: circular buffer of {hdr_flag, data} entries with
// write-side protocol checking and read-side sop/eop marking.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     lfd_state,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     read_enb,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_valid,
  output logic                     sop,
  output logic                     eop,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   pkt_cnt,
  output logic                     wr_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LEN_W = DATA_W - LEN_LSB;
  localparam int unsigned ENT_W = DATA_W + 1;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              af_q, af_d;
  logic              wr_err_q, wr_err_d;

  logic              flush;
  logic              wr_req, wr_legal, wr_acc;
  logic              rd_acc, rd_hdr;
  logic [ENT_W-1:0]  rd_entry;
  logic [DATA_W-1:0] rd_data;
  logic [LEN_W:0]    wr_rem, rd_rem;
  logic              wr_done, rd_done;
  logic [LEN_W-1:0]  wr_len, rd_len;

  assign flush    = reset | soft_reset;
  assign rd_entry = mem_q[rd_ptr_q];
  assign rd_hdr   = rd_entry[DATA_W];
  assign rd_data  = rd_entry[DATA_W-1:0];
  assign wr_len   = LEN_W'(hdr_len(32'(data_in)));
  assign rd_len   = LEN_W'(hdr_len(32'(rd_data)));

  // Accept/drop decisions from pre-edge flags; headers only between packets.
  always_comb begin
    wr_req   = write_enb & ~full_q;
    wr_legal = lfd_state ? (wr_rem == '0) : (wr_rem != '0);
    wr_acc   = wr_req & wr_legal;
    wr_err_d = wr_req & ~wr_legal;
    rd_acc   = read_enb & ~empty_q;
  end

  router_pkt_tracker #(.LEN_W(LEN_W)) u_wr_trk (
    .clk_i    (clock),
    .rst_i    (flush),
    .load_i   (wr_acc & lfd_state),
    .len_i    (wr_len),
    .dec_i    (wr_acc & ~lfd_state),
    .rem_o    (wr_rem),
    .done_c_o (wr_done)
  );

  router_pkt_tracker #(.LEN_W(LEN_W)) u_rd_trk (
    .clk_i    (clock),
    .rst_i    (flush),
    .load_i   (rd_acc & rd_hdr),
    .len_i    (rd_len),
    .dec_i    (rd_acc & ~rd_hdr & (rd_rem != '0)),
    .rem_o    (rd_rem),
    .done_c_o (rd_done)
  );

  // Next-state for pointers, occupancy, packet count and read outputs.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    data_out_d   = data_out_q;
    data_valid_d = rd_acc;
    sop_d        = 1'b0;
    eop_d        = 1'b0;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      data_out_d = rd_data;
      sop_d      = rd_hdr;
      eop_d      = rd_done;
    end
    count_d   = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    pkt_cnt_d = pkt_cnt_q + CNT_W'(wr_done) - CNT_W'(rd_done);
    empty_d   = (count_d == '0);
    full_d    = (count_d == CNT_W'(DEPTH));
    af_d      = (count_d >= CNT_W'(AF_THRESH));
  end

  // Control and output registers; reset and soft_reset flush identically.
  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pkt_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      af_q         <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pkt_cnt_q    <= pkt_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      af_q         <= af_d;
      wr_err_q     <= wr_err_d;
    end
  end

  // Storage array; contents survive a flush since pointers make them stale.
  always_ff @(posedge clock) begin
    if (wr_acc && !flush) mem_q[wr_ptr_q] <= {lfd_state, data_in};
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign sop         = sop_q;
  assign eop         = eop_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign wr_err      = wr_err_q;

endmodule
